// File: rtl/reset_seq_pkg.sv
// Shared types, widths and default timing for the reset sequencer.
// Imported by the sequencer top and its button debouncer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_HOLD_CYCLES     = 256;
   localparam int DEF_STAGE_GAP       = 16;
   localparam int DEF_N_STAGES        = 3;

   // Bits needed to count 0..limit-1, never less than one.
   function automatic int cnt_width(input int limit);
      return (limit <= 2) ? 1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/reset_seq_if.sv
// Reset sequencer signal bundle: raw reset causes in, staged resets out.
// master = sequencer side, slave = the logic that drives/consumes it.
interface reset_seq_if #(
   parameter int N_STAGES = 3
);

   logic                btn_in;
   logic                pll_locked;
   logic [N_STAGES-1:0] rst_out;
   logic                busy;
   logic                btn_db;

   modport master (
      input  btn_in,
      input  pll_locked,
      output rst_out,
      output busy,
      output btn_db
   );

   modport slave (
      output btn_in,
      output pll_locked,
      input  rst_out,
      input  busy,
      input  btn_db
   );

endinterface

// File: rtl/reset_sequencer_button_debouncer.sv
// Front-panel button: 2-flop synchronizer plus stable-sample debouncer.
// The level only changes after DEBOUNCE_CYCLES consecutive differing samples.
module button_debouncer
   import reset_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_btn_db
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_db;
   logic          w_btn_s;

   assign w_btn_s = r_sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_cnt  <= '0;
         r_db   <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_btn};
         // Any agreement, even for one sample, restarts the stability window.
         if (w_btn_s == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == LAST) begin
            r_db  <= w_btn_s;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_btn_db = r_db;

endmodule

// File: rtl/reset_sequencer.sv
// Combines power-on, button and PLL-loss resets and releases the
// downstream stages in order with a minimum pulse width and fixed gaps.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int STAGE_GAP       = DEF_STAGE_GAP,
   parameter int N_STAGES        = DEF_N_STAGES
) (
   input  logic       clk,
   input  logic       rst,
   reset_seq_if.master bus
);

   localparam int HW = cnt_width(HOLD_CYCLES);
   localparam int GW = cnt_width(STAGE_GAP);
   localparam int IW = cnt_width(N_STAGES);

   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N_STAGES - 1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);

   localparam logic [N_STAGES-1:0] ALL_ON  = '1;
   localparam logic [N_STAGES-1:0] BIT_ONE = N_STAGES'(1);

   logic [1:0]          r_lock_sync;
   logic                w_lock_s;
   logic                w_btn_db;
   logic                r_req;
   state_e              r_state;
   logic [HW-1:0]       r_hold;
   logic [GW-1:0]       r_gap;
   logic [IW-1:0]       r_idx;
   logic [N_STAGES-1:0] r_rst_out;
   logic                r_busy;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (bus.btn_in),
      .o_btn_db(w_btn_db)
   );

   assign w_lock_s = r_lock_sync[1];

   // Sync flops reset to 0 so the PLL reads as unlocked during reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock_sync <= '0;
         r_req       <= 1'b1;
      end else begin
         r_lock_sync <= {r_lock_sync[0], bus.pll_locked};
         r_req       <= w_btn_db | ~w_lock_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_ASSERT;
         r_hold    <= '0;
         r_gap     <= '0;
         r_idx     <= '0;
         r_rst_out <= ALL_ON;
         r_busy    <= 1'b1;
      end else if (r_req) begin
         r_state   <= ST_ASSERT;
         r_hold    <= '0;
         r_gap     <= '0;
         r_idx     <= '0;
         r_rst_out <= ALL_ON;
         r_busy    <= 1'b1;
      end else begin
         unique case (r_state)
            ST_ASSERT: begin
               r_rst_out <= ALL_ON;
               r_busy    <= 1'b1;
               if (r_hold != HOLD_LAST) begin
                  r_hold <= r_hold + 1'b1;
               end else if (N_STAGES == 1) begin
                  r_state   <= ST_RUN;
                  r_rst_out <= '0;
                  r_busy    <= 1'b0;
               end else begin
                  r_state   <= ST_RELEASE;
                  r_rst_out <= ALL_ON << 1;
                  r_gap     <= '0;
                  r_idx     <= IDX_ONE;
               end
            end
            ST_RELEASE: begin
               if (r_gap != GAP_LAST) begin
                  r_gap <= r_gap + 1'b1;
               end else begin
                  r_gap     <= '0;
                  r_rst_out <= r_rst_out & ~(BIT_ONE << r_idx);
                  if (r_idx == IDX_LAST) begin
                     r_state <= ST_RUN;
                     r_busy  <= 1'b0;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               r_rst_out <= '0;
               r_busy    <= 1'b0;
            end
            default: begin
               r_state   <= ST_ASSERT;
               r_rst_out <= ALL_ON;
               r_busy    <= 1'b1;
            end
         endcase
      end
   end

   assign bus.rst_out = r_rst_out;
   assign bus.busy    = r_busy;
   assign bus.btn_db  = w_btn_db;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Reset source side of the design. Generates the active-high resets that the per-domain reset synchronizers consume.
- Combines three reset causes: power-on (rst), a debounced front-panel reset button, and loss of PLL lock.
- Guarantees a minimum reset pulse width.
- Releases downstream stages in a fixed order (clocking/ADC interface, then DSP/frequency measurement, then display) with a programmable gap between stages.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples required before the button state is accepted (10 ms at 100 MHz).
- HOLD_CYCLES, 256: minimum number of request-free cycles in ASSERT before stage 0 releases.
- STAGE_GAP, 16: cycles between successive stage releases.
- N_STAGES, 3: number of sequenced reset outputs (must be at least 1).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: global power-on reset.
- btn_in, input, 1: raw push button, asynchronous, active-high, bouncy.
- pll_locked, input, 1: PLL lock indicator, asynchronous to clk.
- rst_out, output, N_STAGES: per-stage reset, active-high, registered. Bit 0 releases first.
- busy, output, 1: high while any rst_out bit is high.
- btn_db, output, 1: debounced button level, for status LED or test.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. While rst is high:
  - all synchronizer flops are 0, so pll lock reads as "not locked";
  - btn_db=0, debounce counter=0, state=ASSERT, hold/gap counters=0;
  - rst_out=all ones, busy=1.
- Input sync: btn_in and pll_locked each pass through 2-flop synchronizers (btn_s, lock_s).
- Debounce:
  - The counter clears whenever btn_s equals btn_db; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while btn_s still differs from btn_db: btn_db <= btn_s and the counter clears.
  - Any single-cycle agreement (bounce back) clears the counter.
- Request: a registered signal req <= btn_db | ~lock_s.
- FSM states: ASSERT, RELEASE, RUN.
  - ASSERT:
    - rst_out all ones.
    - hold_cnt clears whenever req=1, otherwise increments.
    - At the edge where req=0 and hold_cnt==HOLD_CYCLES-1: go to RELEASE, rst_out[0]<=0, gap_cnt<=0, stage index<=1.
  - RELEASE:
    - gap_cnt increments each cycle.
    - When gap_cnt==STAGE_GAP-1: clear rst_out[index], increment index, clear gap_cnt.
    - The edge that clears rst_out[N_STAGES-1] also moves to RUN and sets busy<=0.
    - If N_STAGES==1, ASSERT goes directly to RUN.
  - RUN: rst_out all zeros, busy=0.
  - Any state with req=1: next edge goes to ASSERT, rst_out<=all ones, busy<=1, counters clear.
  - req=1 overrides a release or completion scheduled on the same edge.
- Latency:
  - rst_out[0] falls exactly HOLD_CYCLES edges after req falls.
  - rst_out[k] falls k*STAGE_GAP edges after rst_out[0].
  - Raw pll_locked fall to rst_out reassert: 4 edges (2 sync + req + output).
  - Button press to reassert: 2 + DEBOUNCE_CYCLES + 2 edges.
- Invariants:
  - Reset deassertion is monotonic in stage order: rst_out[k]=0 implies rst_out[j]=0 for all j<k.
  - Every reassertion raises all bits on the same edge.
  - Outputs are glitch-free (flop outputs).
- Width rules:
  - Counters are sized with clog2 of their limit (minimum 1 bit).
  - Counters saturate at their limit; they never wrap.
- Async rst asserted mid-sequence: all outputs return to the reset values immediately (no clock required).

Decomposition:
- Package reset_seq_pkg holds:
  - the state enum (ASSERT, RELEASE, RUN);
  - a clog2 width helper function;
  - default timing constants.
- One sub-module, button_debouncer: its 2-flop sync, counter and btn_db register, parameterised by DEBOUNCE_CYCLES.
- Synchronization of pll_locked stays inline.

Test Plan (DEBOUNCE_CYCLES=8, HOLD_CYCLES=4, STAGE_GAP=2, N_STAGES=3, 10 ns clk):
- Power-on: rst high for 5 cycles with pll_locked=1, then rst low.
  - rst_out=3'b111 during rst.
  - req falls at edge 3 after release of rst; bit0 falls at edge 7, bit1 at edge 9, bit2 at edge 11; busy falls at edge 11.
- Bouncy button: in RUN, btn_in toggles every 3 cycles for 30 cycles, then holds 1.
  - btn_db rises only after 8 stable samples.
  - rst_out goes to 111 exactly 2 edges after btn_db rises; no earlier reassertion.
- PLL loss during RELEASE: drop pll_locked 1 cycle after bit0 falls.
  - rst_out returns to 111 on the 4th edge after the drop.
  - Once relocked, the sequence restarts with the full HOLD_CYCLES.
- Short lock glitch: pll_locked low for 1 cycle in RUN.
  - Reassert occurs.
  - rst_out[0] stays high for at least 4 cycles after req clears (minimum width).
- Async rst mid-RELEASE: rst asserted between clock edges.
  - rst_out=111 and busy=1 before the next edge.
  - After rst falls, the sequence matches the power-on timing.
- Monotonic check: an assertion runs through all scenarios and flags any cycle where a higher rst_out bit is 0 while a lower bit is 1.
